pipe_hazard_ctrl: RTL and testbench

- Central sequencing/hazard controller for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB) with branch prediction.
- Generates stall, flush and forwarding selects, and PC redirects on EX-stage mispredicts.
- Holds mispredict redirects that arrive while the pipe is frozen on a data-memory wait.
- Keeps saturating performance counters for stalls and flushes.

---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/pipe_hazard_ctrl_fwd_unit.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the RV32I pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN           = 2'd0,
        ST_MEM_WAIT      = 2'd1,
        ST_MEM_WAIT_PEND = 2'd2
    } ctrl_state_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Operand forwarding select for one EX source register; the younger MEM result wins over WB.
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic [4:0] mem_rd,
    input  logic       mem_regwrite,
    input  logic [4:0] wb_rd,
    input  logic       wb_regwrite,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_RF;
        // x0 is hardwired to zero, so a write to it must never be forwarded
        if (mem_regwrite && (mem_rd != REG_X0) && (mem_rd == ex_rs)) begin
            sel = FWD_MEM;
        end else if (wb_regwrite && (wb_rd != REG_X0) && (wb_rd == ex_rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward sequencing for the 5-stage pipeline, holding EX mispredicts that
// arrive during a data-memory wait until the wait ends, plus saturating perf counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [4:0]      ex_rs1,
    input  logic [4:0]      ex_rs2,
    input  logic [4:0]      ex_rd,
    input  logic            ex_is_load,
    input  logic            ex_mispredict,
    input  logic [XLEN-1:0] ex_target,
    input  logic [4:0]      mem_rd,
    input  logic [4:0]      wb_rd,
    input  logic            mem_regwrite,
    input  logic            wb_regwrite,
    input  logic            mem_req,
    input  logic            dmem_ready,
    output logic            pc_stall,
    output logic            if_id_stall,
    output logic            id_ex_stall,
    output logic            ex_mem_stall,
    output logic            if_id_flush,
    output logic            id_ex_flush,
    output logic            mem_wb_bubble,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    ctrl_state_e     state, state_nxt;
    logic [XLEN-1:0] pend_target, pend_nxt;
    logic [1:0]      fwd_a_raw, fwd_b_raw;
    logic            mem_wait;
    logic            load_use;

    fwd_unit u_fwd_a (
        .ex_rs        (ex_rs1),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .sel          (fwd_a_raw)
    );

    fwd_unit u_fwd_b (
        .ex_rs        (ex_rs2),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .sel          (fwd_b_raw)
    );

    assign mem_wait = mem_req & ~dmem_ready;
    assign load_use = ex_is_load && (ex_rd != REG_X0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    // Outputs are forced low for the whole time rst is held, even though they are combinational
    assign fwd_a = rst ? 2'b00 : fwd_a_raw;
    assign fwd_b = rst ? 2'b00 : fwd_b_raw;

    always_comb begin
        state_nxt      = state;
        pend_nxt       = pend_target;
        pc_stall       = 1'b0;
        if_id_stall    = 1'b0;
        id_ex_stall    = 1'b0;
        ex_mem_stall   = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        mem_wb_bubble  = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if (!rst) begin
            if (mem_wait) begin
                pc_stall      = 1'b1;
                if_id_stall   = 1'b1;
                id_ex_stall   = 1'b1;
                ex_mem_stall  = 1'b1;
                mem_wb_bubble = 1'b1;
                // EX is frozen, so a mispredict seen now is parked until the wait ends
                if (state != ST_MEM_WAIT_PEND) begin
                    if (ex_mispredict) begin
                        state_nxt = ST_MEM_WAIT_PEND;
                        pend_nxt  = ex_target;
                    end else begin
                        state_nxt = ST_MEM_WAIT;
                    end
                end
            end else if (state == ST_MEM_WAIT_PEND) begin
                state_nxt      = ST_RUN;
                redirect_valid = 1'b1;
                redirect_pc    = pend_target;
                if_id_flush    = 1'b1;
                id_ex_flush    = 1'b1;
            end else begin
                state_nxt = ST_RUN;
                if (ex_mispredict) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = ex_target;
                    if_id_flush    = 1'b1;
                    id_ex_flush    = 1'b1;
                end else if (load_use) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_RUN;
            pend_target <= '0;
        end else begin
            state       <= state_nxt;
            pend_target <= pend_nxt;
        end
    end

    // Only redirect-driven flushes are counted; load-use bubbles are excluded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (redirect_valid && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table plus multi-cycle wait/reset/saturation sequences.
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic        id_use_rs1, id_use_rs2, ex_is_load, ex_mispredict;
    logic [31:0] ex_target;
    logic        mem_regwrite, wb_regwrite, mem_req, dmem_ready;

    logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic        if_id_flush, id_ex_flush, mem_wb_bubble, redirect_valid;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] redirect_pc, stall_cnt, flush_cnt;

    logic        s_pc_stall, s_if_id_stall, s_id_ex_stall, s_ex_mem_stall;
    logic        s_if_id_flush, s_id_ex_flush, s_mem_wb_bubble, s_redirect_valid;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [31:0] s_redirect_pc;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
        .ex_mispredict(ex_mispredict), .ex_target(ex_target),
        .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
        .mem_req(mem_req), .dmem_ready(dmem_ready),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
        .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mem_wb_bubble(mem_wb_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.XLEN(32), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
        .ex_mispredict(ex_mispredict), .ex_target(ex_target),
        .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
        .mem_req(mem_req), .dmem_ready(dmem_ready),
        .pc_stall(s_pc_stall), .if_id_stall(s_if_id_stall), .id_ex_stall(s_id_ex_stall),
        .ex_mem_stall(s_ex_mem_stall), .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
        .mem_wb_bubble(s_mem_wb_bubble), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
        .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    typedef struct {
        string       name;
        logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
        logic        id_use_rs1, id_use_rs2, ex_is_load, ex_mispredict;
        logic [31:0] ex_target;
        logic        mem_regwrite, wb_regwrite, mem_req, dmem_ready;
        logic [3:0]  stl;  // pc, if_id, id_ex, ex_mem stalls
        logic [2:0]  fl;   // if_id_flush, id_ex_flush, mem_wb_bubble
        logic [1:0]  fa, fb;
        logic        rv;
        logic [31:0] rpc;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;

    // Independent state tracker used only to guard the stimulus against an illegal
    // mispredict while a redirect is already parked.
    logic [1:0] m_st;
    always @(posedge clk or posedge rst) begin
        if (rst) m_st <= 2'd0;
        else if (mem_req && !dmem_ready) m_st <= (ex_mispredict || m_st == 2'd2) ? 2'd2 : 2'd1;
        else m_st <= 2'd0;
    end
    always @(posedge clk) begin
        if (!rst) assert (!(m_st == 2'd2 && ex_mispredict && mem_req && !dmem_ready))
            else $error("FAIL stim_mispredict_in_pend");
    end

    function automatic vec_t base(string n);
        vec_t v;
        v.name = n;
        v.id_rs1 = 0; v.id_rs2 = 0; v.ex_rs1 = 0; v.ex_rs2 = 0; v.ex_rd = 0;
        v.mem_rd = 0; v.wb_rd = 0;
        v.id_use_rs1 = 0; v.id_use_rs2 = 0; v.ex_is_load = 0; v.ex_mispredict = 0;
        v.ex_target = 0; v.mem_regwrite = 0; v.wb_regwrite = 0; v.mem_req = 0; v.dmem_ready = 0;
        v.stl = 0; v.fl = 0; v.fa = 0; v.fb = 0; v.rv = 0; v.rpc = 0;
        return v;
    endfunction

    task automatic set_inputs(vec_t v);
        id_rs1 = v.id_rs1; id_rs2 = v.id_rs2; id_use_rs1 = v.id_use_rs1; id_use_rs2 = v.id_use_rs2;
        ex_rs1 = v.ex_rs1; ex_rs2 = v.ex_rs2; ex_rd = v.ex_rd; ex_is_load = v.ex_is_load;
        ex_mispredict = v.ex_mispredict; ex_target = v.ex_target;
        mem_rd = v.mem_rd; wb_rd = v.wb_rd; mem_regwrite = v.mem_regwrite; wb_regwrite = v.wb_regwrite;
        mem_req = v.mem_req; dmem_ready = v.dmem_ready;
    endtask

    task automatic apply(vec_t v);
        set_inputs(v);
        sb.push_back(v);
    endtask

    task automatic check_out();
        vec_t e;
        logic [43:0] obs, want;
        n_checks++;
        if (sb.size() == 0) begin
            $display("FAIL scoreboard_empty got 0 entries want 1");
            return;
        end
        e = sb.pop_front();
        obs  = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush,
                mem_wb_bubble, fwd_a, fwd_b, redirect_valid, redirect_pc};
        want = {e.stl, e.fl, e.fa, e.fb, e.rv, e.rpc};
        if (obs === want) n_pass++;
        else $display("FAIL %s got %h want %h", e.name, obs, want);
        if (!rst && e.stl[3]) exp_stall++;
        if (!rst && e.rv) exp_flush++;
    endtask

    task automatic chk_cnt(string n, logic [31:0] act, logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s got %0d want %0d", n, act, want);
    endtask

    task automatic step(vec_t v);
        @(posedge clk);
        #1;
        apply(v);
        @(negedge clk);
        check_out();
    endtask

    task automatic do_reset();
        set_inputs(base("idle"));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_stall = 0;
        exp_flush = 0;
    endtask

    task automatic mem_wait_seq(int mp_cycle, logic [31:0] tgt);
        vec_t v;
        for (int c = 0; c < 3; c++) begin
            v = base($sformatf("memwait_mp%0d_c%0d", mp_cycle, c));
            v.mem_req = 1; v.dmem_ready = 0;
            v.ex_mispredict = (c == mp_cycle);
            v.ex_target = (c == mp_cycle) ? tgt : 32'hDEAD_BEE0;
            v.stl = 4'b1111; v.fl = 3'b001;
            step(v);
        end
        v = base($sformatf("memwait_mp%0d_release", mp_cycle));
        v.mem_req = 1; v.dmem_ready = 1; v.ex_target = 32'h0000_0123;
        v.rv = 1; v.rpc = tgt; v.fl = 3'b110;
        step(v);
        step(base("memwait_idle_after"));
        chk_cnt("memwait_stall_cnt", stall_cnt, exp_stall);
        chk_cnt("memwait_flush_cnt", flush_cnt, exp_flush);
    endtask

    initial begin
        vec_t v;

        // Reset: inputs that would otherwise stall, forward and redirect
        rst = 1'b1;
        v = base("reset_outputs");
        v.ex_is_load = 1; v.ex_rd = 5; v.id_rs1 = 5; v.id_use_rs1 = 1;
        v.mem_rd = 7; v.mem_regwrite = 1; v.ex_rs1 = 7; v.ex_mispredict = 1; v.ex_target = 32'h400;
        #2;
        apply(v);
        #1;
        check_out();
        chk_cnt("reset_stall_cnt", stall_cnt, 0);
        chk_cnt("reset_flush_cnt", flush_cnt, 0);
        set_inputs(base("idle"));
        @(posedge clk);
        #1;
        rst = 1'b0;

        v = base("idle"); tbl.push_back(v);
        v = base("load_use_rs1");
        v.ex_is_load = 1; v.ex_rd = 5; v.id_rs1 = 5; v.id_use_rs1 = 1;
        v.stl = 4'b1100; v.fl = 3'b010; tbl.push_back(v);
        v = base("load_in_mem_fwd");
        v.mem_rd = 5; v.mem_regwrite = 1; v.ex_rs1 = 5; v.id_rs1 = 5; v.id_use_rs1 = 1;
        v.fa = 2'b10; tbl.push_back(v);
        v = base("load_rs1_unused");
        v.ex_is_load = 1; v.ex_rd = 5; v.id_rs1 = 5; tbl.push_back(v);
        v = base("load_rd_x0");
        v.ex_is_load = 1; v.ex_rd = 0; v.id_rs1 = 0; v.id_use_rs1 = 1; tbl.push_back(v);
        v = base("load_use_rs2");
        v.ex_is_load = 1; v.ex_rd = 9; v.id_rs2 = 9; v.id_use_rs2 = 1; v.id_rs1 = 3; v.id_use_rs1 = 1;
        v.stl = 4'b1100; v.fl = 3'b010; tbl.push_back(v);
        v = base("fwd_mem_over_wb");
        v.mem_rd = 7; v.wb_rd = 7; v.mem_regwrite = 1; v.wb_regwrite = 1; v.ex_rs1 = 7;
        v.fa = 2'b10; tbl.push_back(v);
        v = base("fwd_wb_only");
        v.mem_rd = 7; v.wb_rd = 7; v.mem_regwrite = 0; v.wb_regwrite = 1; v.ex_rs1 = 7;
        v.fa = 2'b01; tbl.push_back(v);
        v = base("fwd_b_x0");
        v.ex_rs2 = 0; v.wb_rd = 0; v.wb_regwrite = 1; v.ex_rs1 = 3; v.mem_rd = 3; v.mem_regwrite = 1;
        v.fa = 2'b10; v.fb = 2'b00; tbl.push_back(v);
        v = base("fwd_a_x0_b_wb");
        v.ex_rs1 = 0; v.mem_rd = 0; v.mem_regwrite = 1; v.ex_rs2 = 4; v.wb_rd = 4; v.wb_regwrite = 1;
        v.fb = 2'b01; tbl.push_back(v);
        v = base("mispredict_over_load_use");
        v.ex_mispredict = 1; v.ex_target = 32'h0000_0400;
        v.ex_is_load = 1; v.ex_rd = 5; v.id_rs1 = 5; v.id_use_rs1 = 1;
        v.rv = 1; v.rpc = 32'h400; v.fl = 3'b110; tbl.push_back(v);

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
        step(base("idle_after_table"));
        chk_cnt("table_stall_cnt", stall_cnt, 2);
        chk_cnt("table_flush_cnt", flush_cnt, 1);

        mem_wait_seq(1, 32'h0000_0080);
        mem_wait_seq(0, 32'h0000_0100);

        // Reset while a redirect is parked
        v = base("pend_enter");
        v.mem_req = 1; v.ex_mispredict = 1; v.ex_target = 32'h200;
        v.stl = 4'b1111; v.fl = 3'b001;
        step(v);
        @(posedge clk);
        #1;
        v = base("pend_hold");
        v.mem_req = 1;
        set_inputs(v);
        #2;
        rst = 1'b1;
        #1;
        v = base("reset_mid_wait");
        v.mem_req = 1; v.mem_rd = 6; v.mem_regwrite = 1; v.ex_rs2 = 6;
        apply(v);
        #1;
        check_out();
        chk_cnt("reset_mid_wait_stall_cnt", stall_cnt, 0);
        chk_cnt("reset_mid_wait_flush_cnt", flush_cnt, 0);
        exp_stall = 0;
        exp_flush = 0;
        set_inputs(base("idle"));
        @(posedge clk);
        #1;
        rst = 1'b0;
        v = base("after_reset_no_redirect");
        v.mem_req = 1; v.dmem_ready = 1;
        step(v);
        step(base("after_reset_idle"));
        chk_cnt("after_reset_flush_cnt", flush_cnt, 0);

        // Saturation on the narrow-counter instance
        do_reset();
        for (int c = 0; c < 20; c++) begin
            v = base($sformatf("sat_wait_%0d", c));
            v.mem_req = 1; v.stl = 4'b1111; v.fl = 3'b001;
            step(v);
        end
        step(base("sat_idle"));
        chk_cnt("sat_stall_cnt_wide", stall_cnt, exp_stall);
        chk_cnt("sat_stall_cnt_4b", {28'd0, s_stall_cnt}, 32'd15);
        chk_cnt("sat_flush_cnt_4b", {28'd0, s_flush_cnt}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
